// File: rtl/i2c_target_regfile.sv
// I2C target with a byte-wide register file: pointer byte then data bytes with
// auto-increment, open-drain SDA, host-side access port and bus event pulses.
module i2c_target_regfile #(
    parameter logic [6:0] SLAVE_ADDRESS = 7'h44,
    parameter int         DEPTH         = 16,
    parameter bit         GEN_CALL_EN   = 1'b1,
    parameter int         FILTER_LEN    = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     scl_i,
    input  logic                     sda_i,
    output logic                     sda_o,
    input  logic [$clog2(DEPTH)-1:0] host_addr_i,
    input  logic                     host_we_i,
    input  logic [7:0]               host_wdata_i,
    output logic [7:0]               host_rdata_o,
    output logic                     start_o,
    output logic                     stop_o,
    output logic                     bus_wr_o,
    output logic                     busy_o
);
    localparam int         AW        = $clog2(DEPTH);
    localparam logic [2:0] FILT_LAST = 3'(FILTER_LEN - 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
    } state_t;

    // bit 1 = SCL, bit 0 = SDA
    logic [1:0] pin_raw;
    logic [1:0] filt;
    logic [1:0] filt_prev_reg;

    assign pin_raw = {scl_i, sda_i};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_filter
            logic       sync1_reg;
            logic       sync2_reg;
            logic       filt_reg;
            logic [2:0] cnt_reg;

            // Filtered level only follows after FILTER_LEN consecutive differing samples
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    sync1_reg <= 1'b1;
                    sync2_reg <= 1'b1;
                    filt_reg  <= 1'b1;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= pin_raw[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg == filt_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == FILT_LAST) begin
                        filt_reg <= sync2_reg;
                        cnt_reg  <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 3'd1;
                    end
                end
            end

            assign filt[gi] = filt_reg;
        end
    endgenerate

    logic scl_f, sda_f, scl_p, sda_p;
    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_f     = filt[1];
    assign sda_f     = filt[0];
    assign scl_p     = filt_prev_reg[1];
    assign sda_p     = filt_prev_reg[0];
    assign scl_rise  = scl_f & ~scl_p;
    assign scl_fall  = ~scl_f & scl_p;
    assign start_det = scl_f & scl_p & sda_p & ~sda_f;
    assign stop_det  = scl_f & scl_p & ~sda_p & sda_f;

    logic [7:0]    regs_reg [DEPTH];

    state_t        state_reg, state_next;
    logic [2:0]    bit_cnt_reg, bit_cnt_next;
    logic [7:0]    shift_reg, shift_next;
    logic [AW-1:0] ptr_reg, ptr_next;
    logic          sda_reg, sda_next;
    logic          ack_rise_reg, ack_rise_next;
    logic          rw_reg, rw_next;
    logic          nack_reg, nack_next;
    logic          start_reg, stop_reg, bus_wr_reg, busy_reg;
    logic [7:0]    host_rdata_reg;

    logic          bus_we;
    logic          byte_done;
    logic          addr_match;
    logic [7:0]    rx_byte;
    logic [7:0]    rd_byte;

    assign rx_byte    = {shift_reg[6:0], sda_f};
    assign rd_byte    = regs_reg[ptr_reg];
    assign byte_done  = scl_rise && (bit_cnt_reg == 3'd7);
    assign addr_match = (rx_byte[7:1] == SLAVE_ADDRESS) ||
                        (GEN_CALL_EN && (rx_byte[7:1] == 7'd0) && !rx_byte[0]);

    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        ptr_next      = ptr_reg;
        sda_next      = sda_reg;
        ack_rise_next = ack_rise_reg;
        rw_next       = rw_reg;
        nack_next     = nack_reg;
        bus_we        = 1'b0;

        // Bus conditions override any bit-level activity in every state
        if (stop_det) begin
            state_next   = IDLE;
            sda_next     = 1'b1;
            bit_cnt_next = '0;
        end else if (start_det) begin
            state_next   = ADDR;
            sda_next     = 1'b1;
            bit_cnt_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                end
                ADDR, PTR, WDATA: begin
                    if (scl_rise) begin
                        shift_next   = rx_byte;
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                    if (byte_done) begin
                        ack_rise_next = 1'b0;
                        if (state_reg == ADDR) begin
                            rw_next    = rx_byte[0];
                            state_next = addr_match ? ADDR_ACK : IDLE;
                        end else if (state_reg == PTR) begin
                            ptr_next   = rx_byte[AW-1:0];
                            state_next = PTR_ACK;
                        end else begin
                            bus_we     = 1'b1;
                            ptr_next   = ptr_reg + AW'(1);
                            state_next = WDATA_ACK;
                        end
                    end
                end
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    // First fall drives the ACK, the fall after the ACK clock ends it
                    if (scl_fall) begin
                        if (!ack_rise_reg) begin
                            sda_next = 1'b0;
                        end else begin
                            sda_next     = 1'b1;
                            bit_cnt_next = '0;
                            if (state_reg == ADDR_ACK && rw_reg) begin
                                state_next = RDATA;
                                shift_next = {rd_byte[6:0], 1'b0};
                                sda_next   = rd_byte[7];
                            end else if (state_reg == ADDR_ACK) begin
                                state_next = PTR;
                            end else begin
                                state_next = WDATA;
                            end
                        end
                    end else if (scl_rise) begin
                        ack_rise_next = 1'b1;
                    end
                end
                RDATA: begin
                    if (scl_fall) begin
                        sda_next   = shift_reg[7];
                        shift_next = {shift_reg[6:0], 1'b0};
                    end
                    if (scl_rise) begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                    if (byte_done) begin
                        ack_rise_next = 1'b0;
                        state_next    = RDATA_ACK;
                    end
                end
                RDATA_ACK: begin
                    if (scl_fall) begin
                        if (!ack_rise_reg) begin
                            sda_next = 1'b1;
                        end else if (nack_reg) begin
                            sda_next   = 1'b1;
                            state_next = IDLE;
                        end else begin
                            state_next   = RDATA;
                            bit_cnt_next = '0;
                            shift_next   = {rd_byte[6:0], 1'b0};
                            sda_next     = rd_byte[7];
                        end
                    end else if (scl_rise && !ack_rise_reg) begin
                        ack_rise_next = 1'b1;
                        nack_next     = sda_f;
                        ptr_next      = ptr_reg + AW'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    sda_next   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            filt_prev_reg  <= 2'b11;
            state_reg      <= IDLE;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            ptr_reg        <= '0;
            sda_reg        <= 1'b1;
            ack_rise_reg   <= 1'b0;
            rw_reg         <= 1'b0;
            nack_reg       <= 1'b0;
            start_reg      <= 1'b0;
            stop_reg       <= 1'b0;
            bus_wr_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            host_rdata_reg <= '0;
        end else begin
            filt_prev_reg  <= filt;
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            ptr_reg        <= ptr_next;
            sda_reg        <= sda_next;
            ack_rise_reg   <= ack_rise_next;
            rw_reg         <= rw_next;
            nack_reg       <= nack_next;
            start_reg      <= start_det;
            stop_reg       <= stop_det;
            bus_wr_reg     <= bus_we;
            if (stop_det) begin
                busy_reg <= 1'b0;
            end else if (start_det) begin
                busy_reg <= 1'b1;
            end
            host_rdata_reg <= regs_reg[host_addr_i];
        end
    end

    // The bus write is issued last so it wins a same-index collision with the host
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            if (host_we_i) begin
                regs_reg[host_addr_i] <= host_wdata_i;
            end
            if (bus_we) begin
                regs_reg[ptr_reg] <= rx_byte;
            end
        end
    end

    assign sda_o        = sda_reg;
    assign host_rdata_o = host_rdata_reg;
    assign start_o      = start_reg;
    assign stop_o       = stop_reg;
    assign bus_wr_o     = bus_wr_reg;
    assign busy_o       = busy_reg;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-banged I2C master plus host port, checked
// against an array/pointer model of the register file.
module tb_i2c_target_regfile;
    localparam logic [6:0] SLV   = 7'h44;
    localparam int         DEPTH = 16;
    localparam int         Q     = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_o;
    logic       sda_bus;
    logic [3:0] host_addr = '0;
    logic       host_we = 1'b0;
    logic [7:0] host_wdata = '0;
    logic [7:0] host_rdata;
    logic       start_o, stop_o, bus_wr_o, busy_o;

    int n_checks = 0;
    int n_fail   = 0;
    int start_cnt = 0, stop_cnt = 0, bus_wr_cnt = 0;

    logic [7:0] mdl_regs [DEPTH];
    int         mdl_ptr = 0;
    logic [7:0] wbuf [8];

    assign sda_bus = m_sda & sda_o;
    always #5 clk = ~clk;

    i2c_target_regfile #(
        .SLAVE_ADDRESS(SLV),
        .DEPTH        (DEPTH),
        .GEN_CALL_EN  (1'b1),
        .FILTER_LEN   (3)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .scl_i       (m_scl),
        .sda_i       (sda_bus),
        .sda_o       (sda_o),
        .host_addr_i (host_addr),
        .host_we_i   (host_we),
        .host_wdata_i(host_wdata),
        .host_rdata_o(host_rdata),
        .start_o     (start_o),
        .stop_o      (stop_o),
        .bus_wr_o    (bus_wr_o),
        .busy_o      (busy_o)
    );

    always @(posedge clk) begin
        if (start_o)  start_cnt++;
        if (stop_o)   stop_cnt++;
        if (bus_wr_o) bus_wr_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        m_sda = 1'b1; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b1; wait_q();
        wait_q();
    endtask

    task automatic write_bit(input logic b);
        m_sda = b; wait_q();
        m_scl = 1'b1; wait_q();
        wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; wait_q();
        m_scl = 1'b1; wait_q();
        b = sda_bus; wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack_lvl);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(ack_lvl);
    endtask

    task automatic recv_byte(output logic [7:0] b, input logic nack);
        logic v;
        for (int i = 7; i >= 0; i--) begin
            read_bit(v);
            b[i] = v;
        end
        write_bit(nack);
    endtask

    task automatic xfer_write(input logic [6:0] a, input logic [7:0] p, input int nw, input bit do_stop);
        logic lvl;
        bit   exp_ack;
        int   wr0;
        wr0     = bus_wr_cnt;
        exp_ack = (a == SLV) || (a == 7'h00);
        bus_start();
        check_eq("busy_after_start", 32'(busy_o), 32'(1));
        send_byte({a, 1'b0}, lvl);
        check_eq("wr_addr_ack", 32'(lvl), 32'(!exp_ack));
        if (exp_ack) begin
            send_byte(p, lvl);
            check_eq("ptr_ack", 32'(lvl), 32'(0));
            mdl_ptr = int'(p) % DEPTH;
            for (int i = 0; i < nw; i++) begin
                send_byte(wbuf[i], lvl);
                check_eq("data_ack", 32'(lvl), 32'(0));
                mdl_regs[mdl_ptr] = wbuf[i];
                mdl_ptr = (mdl_ptr + 1) % DEPTH;
            end
        end
        if (do_stop) begin
            bus_stop();
            check_eq("busy_after_stop", 32'(busy_o), 32'(0));
        end
        check_eq("bus_wr_count", 32'(bus_wr_cnt - wr0), exp_ack ? 32'(nw) : 32'(0));
        $display("txn write addr=%02h ptr=%02h bytes=%0d ack=%0d stop=%0d", a, p, nw, exp_ack, do_stop);
    endtask

    task automatic xfer_read(input logic [6:0] a, input int n);
        logic       lvl;
        logic [7:0] b;
        bit         exp_ack;
        exp_ack = (a == SLV);
        bus_start();
        send_byte({a, 1'b1}, lvl);
        check_eq("rd_addr_ack", 32'(lvl), 32'(!exp_ack));
        if (exp_ack) begin
            for (int i = 0; i < n; i++) begin
                recv_byte(b, i == n - 1);
                check_eq("rd_data", 32'(b), 32'(mdl_regs[mdl_ptr]));
                mdl_ptr = (mdl_ptr + 1) % DEPTH;
            end
        end
        bus_stop();
        check_eq("busy_after_stop", 32'(busy_o), 32'(0));
        $display("txn read addr=%02h bytes=%0d ack=%0d", a, n, exp_ack);
    endtask

    task automatic host_write(input int idx, input logic [7:0] d);
        @(posedge clk); #1;
        host_addr  = 4'(idx);
        host_wdata = d;
        host_we    = 1'b1;
        @(posedge clk); #1;
        host_we    = 1'b0;
        mdl_regs[idx] = d;
        $display("txn host write idx=%0d data=%02h", idx, d);
    endtask

    task automatic host_read(input int idx, output logic [7:0] v);
        @(posedge clk); #1;
        host_addr = 4'(idx);
        @(posedge clk);
        @(posedge clk); #1;
        v = host_rdata;
    endtask

    task automatic host_check(input int idx);
        logic [7:0] v;
        host_read(idx, v);
        check_eq("host_rdata", 32'(v), 32'(mdl_regs[idx]));
    endtask

    function automatic logic [6:0] pick_addr();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 7'h00;
        if (r == 1) return 7'h45;
        if (r == 2) return 7'($urandom_range(0, 127));
        return SLV;
    endfunction

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        logic       lvl;
        int         s0, p0, kind, nw, idx;
        logic [6:0] a;
        logic [7:0] p;

        for (int i = 0; i < DEPTH; i++) mdl_regs[i] = 8'h00;

        // Reset state
        repeat (5) @(posedge clk); #1;
        check_eq("rst_sda_o", 32'(sda_o), 32'(1));
        check_eq("rst_host_rdata", 32'(host_rdata), 32'(0));
        check_eq("rst_pulses", 32'({start_o, stop_o, bus_wr_o, busy_o}), 32'(0));
        rst = 1'b0;
        repeat (5) @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++) host_check(i);

        // Write pointer 2, data A5 5A
        wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
        xfer_write(SLV, 8'h02, 2, 1'b1);
        host_read(2, v); check_eq("t1_reg2", 32'(v), 32'h A5);
        host_read(3, v); check_eq("t1_reg3", 32'(v), 32'h 5A);

        // Pointer wrap at the top of the file
        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        xfer_write(SLV, 8'h0F, 2, 1'b1);
        host_read(15, v); check_eq("t2_reg15", 32'(v), 32'h 11);
        host_read(0, v);  check_eq("t2_reg0", 32'(v), 32'h 22);
        xfer_read(SLV, 1);

        // Host preload, pointer write, repeated START, read two bytes
        host_write(4, 8'hC3);
        host_write(5, 8'h3C);
        s0 = start_cnt; p0 = stop_cnt;
        xfer_write(SLV, 8'h04, 0, 1'b0);
        xfer_read(SLV, 2);
        check_eq("t3_start_pulses", 32'(start_cnt - s0), 32'(2));
        check_eq("t3_stop_pulses", 32'(stop_cnt - p0), 32'(1));

        // Wrong address then general call
        wbuf[0] = 8'hE7;
        xfer_write(7'h45, 8'h00, 0, 1'b1);
        xfer_write(7'h00, 8'h08, 1, 1'b1);
        host_read(8, v); check_eq("t5_gencall_reg8", 32'(v), 32'h E7);
        xfer_read(7'h00, 1);

        // Reset during the third bit of a read byte
        host_write(7, 8'h9F);
        xfer_write(SLV, 8'h07, 0, 1'b0);
        bus_start();
        send_byte({SLV, 1'b1}, lvl);
        check_eq("t6_addr_ack", 32'(lvl), 32'(0));
        read_bit(lvl); check_eq("t6_bit7", 32'(lvl), 32'(1));
        read_bit(lvl); check_eq("t6_bit6", 32'(lvl), 32'(0));
        m_sda = 1'b1; wait_q();
        check_eq("t6_bit5_driven", 32'(sda_o), 32'(0));
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check_eq("t6_rst_sda_release", 32'(sda_o), 32'(1));
        check_eq("t6_rst_busy", 32'(busy_o), 32'(0));
        m_scl = 1'b1; m_sda = 1'b1;
        repeat (4) @(posedge clk); #3;
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl_regs[i] = 8'h00;
        mdl_ptr = 0;
        $display("txn reset mid-read");
        repeat (20) @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++) host_check(i);
        wbuf[0] = 8'h6B;
        xfer_write(SLV, 8'h03, 1, 1'b1);
        xfer_write(SLV, 8'h03, 0, 1'b0);
        xfer_read(SLV, 1);

        // Randomized mix of bus and host traffic
        for (int t = 0; t < 14; t++) begin
            kind = int'($urandom_range(0, 3));
            a    = pick_addr();
            p    = 8'($urandom_range(0, 255));
            case (kind)
                0: begin
                    nw = int'($urandom_range(1, 4));
                    for (int i = 0; i < nw; i++) wbuf[i] = 8'($urandom_range(0, 255));
                    xfer_write(a, p, nw, 1'b1);
                end
                1: xfer_read(a, int'($urandom_range(1, 4)));
                2: begin
                    xfer_write(a, p, 0, 1'b0);
                    xfer_read(SLV, int'($urandom_range(1, 4)));
                end
                default: begin
                    idx = int'($urandom_range(0, DEPTH - 1));
                    host_write(idx, 8'($urandom_range(0, 255)));
                    host_check(idx);
                end
            endcase
        end

        for (int i = 0; i < DEPTH; i++) host_check(i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
